instr_controller: RTL and testbench
===================================

# instr_controller

Multi-cycle instruction decode and control FSM that sits directly upstream of the register-bank/ALU datapath. It accepts one 16-bit instruction per valid/ready handshake. It decodes the instruction into the datapath control bus: write-enable one-hot, ALU opcode, Rdest/Rsrc selects, immediate and immediate select. It sequences decode, execute and write-back, and captures the ALU flags returned by the datapath.

## Interface
Parameters:
- CMP_EXT, 4'b1011, opcode-extension / immediate-op code meaning "compare": flags update, no register write.
- UNSUP_OP0, 4'b0100, major op treated as unsupported (load/store/jump class).
- UNSUP_OP1, 4'b1100, major op treated as unsupported (branch class).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset. 0 = reset, sampled on rising edge of clk.
- instr_valid  in  1  upstream has an instruction on instr.
- instr  in  16  instruction word.
- instr_ready  out  1  controller can accept; 1 only in S_IDLE and reset=1.
- Flags_in  in  5  ALU flags from datapath.
- wEnable  out  16  one-hot register write enable to datapath.
- opcode  out  8  ALU opcode to datapath.
- Rdest_select  out  4  Rdest mux select.
- Rsrc_select  out  4  Rsrc mux select.
- Imm_select  out  1  1 = ALU B operand is Imm_in.
- Imm_in  out  16  sign-extended immediate.
- flags_q  out  5  last captured ALU flags.
- done  out  1  1-cycle pulse in S_WB of every accepted instruction.
- illegal  out  1  1-cycle pulse in S_WB for unsupported instruction.

## Operation
- Instruction fields: op = instr[15:12], rd = instr[11:8], ext = instr[7:4], rs = instr[3:0], imm8 = instr[7:0].
- Register form (op == 0):
  - opcode = {4'h0, ext}, Rdest_select = rd, Rsrc_select = rs.
  - Imm_select = 0, Imm_in = 0.
- Immediate form (op != 0, not unsupported):
  - opcode = {op, 4'h0}, Rdest_select = rd, Rsrc_select = 0.
  - Imm_select = 1, Imm_in = {{8{imm8[7]}}, imm8}.
- Write suppression: no write if register form with ext == CMP_EXT, or immediate form with op == CMP_EXT. Flags are still captured.
- Unsupported (op == UNSUP_OP0 or UNSUP_OP1):
  - All control outputs driven 0, no write, flags_q unchanged.
  - illegal pulses with done.
- FSM states and transitions:
  - S_IDLE -> S_DECODE on instr_valid & instr_ready; instr latched into internal IR.
  - S_DECODE -> S_EXEC unconditionally; decoded controls registered from IR.
  - S_EXEC -> S_WB unconditionally; flags_q <= Flags_in (unless unsupported); wEnable <= (1 << rd) if writing, else 0.
  - S_WB -> S_IDLE unconditionally; wEnable <= 0.
- opcode, selects, Imm_in and Imm_select hold from entry to S_EXEC through S_WB and until the next decode, so the ALU result is stable at the write edge.
- instr_valid while not ready is ignored; the instruction is not latched.

## Timing
- Reset (reset = 0 at an edge), from any state:
  - state = S_IDLE.
  - wEnable, opcode, Rdest_select, Rsrc_select, Imm_select, Imm_in, flags_q, done and illegal all 0.
  - instr_ready is 0 while reset = 0.
- Reset in S_WB: wEnable cleared at that edge. The write still lands only if the datapath samples wEnable on the same edge; the datapath is itself in reset, so this is don't-care.
- Accept edge E0:
  - E1: controls valid.
  - E2: flags_q updated; wEnable asserted for cycle E2–E3 with done/illegal.
  - E3: register written by datapath; controller back in S_IDLE.
- Throughput: 1 instruction per 4 cycles. instr_ready is 0 for exactly 3 cycles after each accept.
- wEnable is never high for more than 1 cycle and never has more than 1 bit set.

## Test plan
- Reset then ADD r3,r5 (instr 16'h0355):
  - E1: opcode 8'h05, Rdest_select 3, Rsrc_select 5, Imm_select 0.
  - S_WB cycle only: wEnable 16'h0008, done 1.
- ADDI r2,#-1 (16'h52FF):
  - opcode 8'h50, Imm_in 16'hFFFF, Imm_select 1.
  - wEnable 16'h0004 for exactly 1 cycle.
- CMP r1,r2 (16'h01B2) with Flags_in = 5'b10101 during S_EXEC:
  - flags_q = 5'b10101 after E2.
  - wEnable stays 16'h0000, done pulses.
- Unsupported 16'h4123 (and 16'hC0FF):
  - illegal and done pulse together, wEnable 0, flags_q unchanged.
- instr_valid held high with two instructions back to back:
  - accepts 4 cycles apart.
  - instr_ready low for 3 cycles after each accept.
  - second instruction not latched early.
- reset driven 0 during S_EXEC of 16'h0355:
  - next cycle state IDLE, all outputs 0.
  - no wEnable pulse ever appears for that instruction.

Source files
------------

// File: rtl/instr_controller_if.sv
// Handshake and control bus between the instruction source, the decode/control
// FSM and the register-bank/ALU datapath.
interface instr_controller_if;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [4:0]  Flags_in;
  logic [15:0] wEnable;
  logic [7:0]  opcode;
  logic [3:0]  Rdest_select;
  logic [3:0]  Rsrc_select;
  logic        Imm_select;
  logic [15:0] Imm_in;
  logic [4:0]  flags_q;
  logic        done;
  logic        illegal;

  modport master (
    output instr_valid, instr, Flags_in,
    input  instr_ready, wEnable, opcode, Rdest_select, Rsrc_select,
           Imm_select, Imm_in, flags_q, done, illegal
  );

  modport slave (
    input  instr_valid, instr, Flags_in,
    output instr_ready, wEnable, opcode, Rdest_select, Rsrc_select,
           Imm_select, Imm_in, flags_q, done, illegal
  );
endinterface

// File: rtl/instr_controller.sv
// Four-state instruction decode/control FSM: accepts one 16-bit instruction,
// drives the datapath control bus, pulses a one-hot write and captures ALU flags.
module instr_controller #(
  parameter logic [3:0] CMP_EXT   = 4'b1011,
  parameter logic [3:0] UNSUP_OP0 = 4'b0100,
  parameter logic [3:0] UNSUP_OP1 = 4'b1100
) (
  input logic               clk,
  input logic               reset,
  instr_controller_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

  state_t      state, state_nxt;
  logic [15:0] ir_p0;
  logic        accept;

  logic [3:0]  op, rd, ext, rs;
  logic [7:0]  imm8;
  logic        unsup, writes;

  logic [7:0]  opcode_d;
  logic [3:0]  rdest_d, rsrc_d;
  logic        imm_sel_d;
  logic [15:0] imm_d;
  logic [15:0] wen_d;

  function automatic logic signed [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  assign bus.instr_ready = (state == S_IDLE) && reset;
  assign accept          = bus.instr_valid && bus.instr_ready;

  assign op     = ir_p0[15:12];
  assign rd     = ir_p0[11:8];
  assign ext    = ir_p0[7:4];
  assign rs     = ir_p0[3:0];
  assign imm8   = ir_p0[7:0];
  assign unsup  = (op == UNSUP_OP0) || (op == UNSUP_OP1);
  assign writes = !unsup && ((op == 4'h0) ? (ext != CMP_EXT) : (op != CMP_EXT));
  assign wen_d  = writes ? (16'd1 << rd) : 16'd0;

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Unsupported instructions decode to an all-zero control word.
  always_comb begin
    opcode_d  = 8'h00;
    rdest_d   = 4'h0;
    rsrc_d    = 4'h0;
    imm_sel_d = 1'b0;
    imm_d     = 16'h0000;
    if (!unsup) begin
      rdest_d = rd;
      if (op == 4'h0) begin
        opcode_d = {4'h0, ext};
        rsrc_d   = rs;
      end else begin
        opcode_d  = {op, 4'h0};
        imm_sel_d = 1'b1;
        imm_d     = sext8(imm8);
      end
    end
  end

  // Instruction register: only loaded on an accepted handshake.
  always_ff @(posedge clk) begin
    if (accept) ir_p0 <= bus.instr;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.wEnable      <= 16'h0000;
      bus.opcode       <= 8'h00;
      bus.Rdest_select <= 4'h0;
      bus.Rsrc_select  <= 4'h0;
      bus.Imm_select   <= 1'b0;
      bus.Imm_in       <= 16'h0000;
      bus.flags_q      <= 5'h00;
      bus.done         <= 1'b0;
      bus.illegal      <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.illegal <= 1'b0;
      case (state)
        S_DECODE: begin
          bus.opcode       <= opcode_d;
          bus.Rdest_select <= rdest_d;
          bus.Rsrc_select  <= rsrc_d;
          bus.Imm_select   <= imm_sel_d;
          bus.Imm_in       <= imm_d;
        end
        S_EXEC: begin
          if (!unsup) bus.flags_q <= bus.Flags_in;
          bus.wEnable <= wen_d;
          bus.done    <= 1'b1;
          bus.illegal <= unsup;
        end
        S_WB: bus.wEnable <= 16'h0000;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_controller.sv
// Randomized and directed bench for instr_controller against a behavioural
// decode model computed from the instruction-format rules.
module tb_instr_controller;

  localparam logic [3:0] CMP  = 4'b1011;
  localparam logic [3:0] UNS0 = 4'b0100;
  localparam logic [3:0] UNS1 = 4'b1100;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [4:0] exp_flags = 5'h00;

  instr_controller_if bus();

  instr_controller #(.CMP_EXT(CMP), .UNSUP_OP0(UNS0), .UNSUP_OP1(UNS1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] ctl();
    return {bus.opcode, bus.Rdest_select, bus.Rsrc_select, bus.Imm_select, bus.Imm_in};
  endfunction

  function automatic logic [56:0] all_out();
    return {bus.instr_ready, bus.wEnable, ctl(), bus.flags_q, bus.done, bus.illegal};
  endfunction

  // Reference model: control word {opcode, rd, rs, imm_sel, imm}
  function automatic logic [32:0] m_ctl(input logic [15:0] i);
    logic [3:0] op = i[15:12];
    int v;
    logic [15:0] imm;
    if (op == UNS0 || op == UNS1) return 33'd0;
    if (op == 4'h0) return {4'h0, i[7:4], i[11:8], i[3:0], 1'b0, 16'h0000};
    v = i[7:0];
    if (v > 127) v = v - 256;
    imm = v[15:0];
    return {op, 4'h0, i[11:8], 4'h0, 1'b1, imm};
  endfunction

  function automatic logic m_ill(input logic [15:0] i);
    return (i[15:12] == UNS0) || (i[15:12] == UNS1);
  endfunction

  function automatic logic [15:0] m_wen(input logic [15:0] i);
    int p;
    if (m_ill(i)) return 16'h0000;
    if (i[15:12] == 4'h0 && i[7:4] == CMP) return 16'h0000;
    if (i[15:12] == CMP) return 16'h0000;
    p = 2 ** int'(i[11:8]);
    return p[15:0];
  endfunction

  task automatic do_instr(input logic [15:0] i, input logic [4:0] f, input logic [32:0] ec,
                          input logic [15:0] ew, input logic ei, input string nm);
    n_tests++;
    if (bus.instr_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s idle_ready got %b want 1", nm, bus.instr_ready);
    end
    bus.instr = i; bus.instr_valid = 1'b1; bus.Flags_in = ~f;
    tick();
    bus.instr_valid = 1'b0; bus.instr = $urandom;
    n_tests++;
    if ({bus.instr_ready, bus.done, bus.wEnable} !== 18'd0) begin
      n_fail++; $display("FAIL %s decode_status got %h want 0", nm, {bus.instr_ready, bus.done, bus.wEnable});
    end
    tick();
    n_tests++;
    if (ctl() !== ec) begin
      n_fail++; $display("FAIL %s controls got %h want %h", nm, ctl(), ec);
    end
    bus.Flags_in = f;
    tick();
    if (!ei) exp_flags = f;
    n_tests++;
    if ({bus.flags_q, bus.wEnable, bus.done, bus.illegal, bus.instr_ready} !== {exp_flags, ew, 1'b1, ei, 1'b0}) begin
      n_fail++; $display("FAIL %s wb got fl=%b wen=%h done=%b ill=%b rdy=%b want fl=%b wen=%h done=1 ill=%b rdy=0",
                         nm, bus.flags_q, bus.wEnable, bus.done, bus.illegal, bus.instr_ready, exp_flags, ew, ei);
    end
    bus.Flags_in = $urandom;
    tick();
    n_tests++;
    if ({bus.instr_ready, bus.done, bus.illegal, bus.wEnable, ctl(), bus.flags_q} !== {3'b100, 16'h0000, ec, exp_flags}) begin
      n_fail++; $display("FAIL %s after_wb got rdy=%b done=%b ill=%b wen=%h ctl=%h fl=%b want rdy=1 wen=0 ctl=%h fl=%b",
                         nm, bus.instr_ready, bus.done, bus.illegal, bus.wEnable, ctl(), bus.flags_q, ec, exp_flags);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.instr_valid = 1'b1; bus.instr = 16'h0355; bus.Flags_in = 5'h1F;
    tick(); tick();
    n_tests++;
    if (all_out() !== 57'd0) begin
      n_fail++; $display("FAIL reset_outputs got %h want 0", all_out());
    end
    bus.instr_valid = 1'b0;
    reset = 1'b1;
    tick();
    n_tests++;
    if (bus.instr_ready !== 1'b1 || bus.wEnable !== 16'h0) begin
      n_fail++; $display("FAIL reset_release got rdy=%b wen=%h want rdy=1 wen=0", bus.instr_ready, bus.wEnable);
    end
    exp_flags = 5'h00;
  endtask

  task automatic test_directed();
    do_instr(16'h0355, 5'b00011, {8'h05, 4'd3, 4'd5, 1'b0, 16'h0000}, 16'h0008, 1'b0, "add_r3_r5");
    do_instr(16'h52FF, 5'b01000, {8'h50, 4'd2, 4'd0, 1'b1, 16'hFFFF}, 16'h0004, 1'b0, "addi_r2_m1");
    do_instr(16'h01B2, 5'b10101, {8'h0B, 4'd1, 4'd2, 1'b0, 16'h0000}, 16'h0000, 1'b0, "cmp_r1_r2");
    do_instr(16'h4123, 5'b01010, 33'd0, 16'h0000, 1'b1, "unsup_4123");
    do_instr(16'hC0FF, 5'b00001, 33'd0, 16'h0000, 1'b1, "unsup_c0ff");
    do_instr(16'hB7F0, 5'b00110, {8'hB0, 4'd7, 4'd0, 1'b1, 16'hFFF0}, 16'h0000, 1'b0, "cmpi_r7");
  endtask

  task automatic test_random();
    logic [15:0] i;
    logic [4:0]  f;
    for (int k = 0; k < 40; k++) begin
      i = $urandom;
      f = $urandom;
      case ($urandom_range(0, 4))
        0: i[15:12] = 4'h0;
        1: begin i[15:12] = 4'h0; i[7:4] = CMP; end
        2: i[15:12] = CMP;
        default: ;
      endcase
      do_instr(i, f, m_ctl(i), m_wen(i), m_ill(i), $sformatf("rand%0d_%h", k, i));
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a = 16'h0A21;
    logic [15:0] b = 16'h6E80;
    bus.Flags_in = 5'b11001;
    bus.instr = a; bus.instr_valid = 1'b1;
    tick();
    bus.instr = b;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (bus.instr_ready !== 1'b0) begin
        n_fail++; $display("FAIL b2b_busy%0d ready got %b want 0", k, bus.instr_ready);
      end
      if (k == 1) begin
        n_tests++;
        if (ctl() !== m_ctl(a)) begin
          n_fail++; $display("FAIL b2b_first_ctl got %h want %h", ctl(), m_ctl(a));
        end
      end
      if (k == 2) begin
        n_tests++;
        if (bus.wEnable !== m_wen(a)) begin
          n_fail++; $display("FAIL b2b_first_wen got %h want %h", bus.wEnable, m_wen(a));
        end
      end
      tick();
    end
    exp_flags = 5'b11001;
    n_tests++;
    if (bus.instr_ready !== 1'b1 || ctl() !== m_ctl(a) || bus.wEnable !== 16'h0) begin
      n_fail++; $display("FAIL b2b_gap got rdy=%b ctl=%h wen=%h want rdy=1 ctl=%h wen=0", bus.instr_ready, ctl(), bus.wEnable, m_ctl(a));
    end
    tick();
    bus.instr_valid = 1'b0;
    n_tests++;
    if (bus.instr_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second_accept ready got %b want 0", bus.instr_ready);
    end
    bus.Flags_in = 5'b00110;
    tick();
    n_tests++;
    if (ctl() !== m_ctl(b)) begin
      n_fail++; $display("FAIL b2b_second_ctl got %h want %h", ctl(), m_ctl(b));
    end
    tick();
    exp_flags = 5'b00110;
    n_tests++;
    if (bus.wEnable !== m_wen(b) || bus.flags_q !== exp_flags || bus.done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second_wb got wen=%h fl=%b done=%b want wen=%h fl=%b done=1", bus.wEnable, bus.flags_q, bus.done, m_wen(b), exp_flags);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.instr = 16'h0355; bus.instr_valid = 1'b1; bus.Flags_in = 5'b11111;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    n_tests++;
    if (all_out() !== 57'd0) begin
      n_fail++; $display("FAIL reset_in_exec got %h want 0", all_out());
    end
    reset = 1'b1;
    exp_flags = 5'h00;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++;
      if (bus.wEnable !== 16'h0 || bus.done !== 1'b0 || bus.instr_ready !== 1'b1) begin
        n_fail++; $display("FAIL reset_no_write%0d got wen=%h done=%b rdy=%b want wen=0 done=0 rdy=1", k, bus.wEnable, bus.done, bus.instr_ready);
      end
    end
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr = 16'h0000;
    bus.Flags_in = 5'h00;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    do_instr(16'h0355, 5'b00100, m_ctl(16'h0355), m_wen(16'h0355), 1'b0, "post_reset_add");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
